// File: rtl/instr_fetch_queue.sv
// Instruction-fetch queue: owns the fetch PC, issues single-outstanding
// req/ack reads to instruction memory and buffers returned words for decode.
// The head entry is presented to decode with opcode and imm16 split out.
// Redirects flush the queue and squash any read already in flight.
// Build option: define IFQ_BYPASS_EN to forward an unsquashed ack straight to
// the decode outputs in the same cycle when the queue is empty.
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   output logic                     imem_req_o,
   output logic [31:0]              imem_addr_o,
   input  logic                     imem_ack_i,
   input  logic [31:0]              imem_data_i,
   input  logic                     redirect_i,
   input  logic [31:0]              redirect_pc_i,
   output logic                     dec_valid_o,
   input  logic                     dec_ready_i,
   output logic [31:0]              dec_instr_o,
   output logic [31:0]              dec_pc_o,
   output logic [5:0]               dec_opcode_o,
   output logic [15:0]              dec_imm16_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            req_q, req_d;
   logic [31:0]     addr_q, addr_d;
   logic            squash_q, squash_d;
   logic [31:0]     redir_pc_q, redir_pc_d;

   logic            ack_vld;
   logic            q_empty;
   logic            q_pop;
   logic            push;
   logic            byp_hit;
   logic            space;
   logic [31:0]     redir_pc_aligned;
   entry_t          head;

   assign ack_vld          = req_q & imem_ack_i;
   assign q_empty          = (level_q == '0);
   assign q_pop            = ~q_empty & dec_ready_i;
   assign redir_pc_aligned = redirect_pc_i & 32'hFFFF_FFFC;
   assign head             = mem_q[rd_ptr_q];

`ifdef IFQ_BYPASS_EN
   assign byp_hit = q_empty & ack_vld & ~squash_q & ~redirect_i;
`else
   assign byp_hit = 1'b0;
`endif

   // A word is written unless it is squashed, flushed by a redirect, or
   // consumed directly by decode through the bypass.
   assign push  = ack_vld & ~squash_q & ~redirect_i & ~(byp_hit & dec_ready_i);
   assign space = (level_d < DEPTH_L);

   // Decode-facing view of the head entry (or the bypassed ack word).
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      dec_valid_o = ~q_empty;
      dec_instr_o = q_empty ? 32'h0 : head.instr;
      dec_pc_o    = q_empty ? 32'h0 : head.pc;
`ifdef IFQ_BYPASS_EN
      if (byp_hit) begin
         dec_valid_o = 1'b1;
         dec_instr_o = imem_data_i;
         dec_pc_o    = addr_q;
      end
`endif
   end

   assign dec_opcode_o = dec_instr_o[31:26];
   assign dec_imm16_o  = dec_instr_o[15:0];
   assign imem_req_o   = req_q;
   assign imem_addr_o  = addr_q;
   assign level_o      = level_q;

   // Queue occupancy and pointers: a redirect empties the queue outright.
   always_comb begin
      if (redirect_i) begin
         level_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         level_d  = level_q + LW'(push) - LW'(q_pop);
         rd_ptr_d = rd_ptr_q + AW'(q_pop);
         wr_ptr_d = wr_ptr_q + AW'(push);
      end
   end

   // Fetch request, address and squash bookkeeping.
   always_comb begin
      req_d      = req_q;
      addr_d     = addr_q;
      squash_d   = squash_q;
      redir_pc_d = redir_pc_q;
      if (redirect_i) begin
         redir_pc_d = redir_pc_aligned;
         if (!req_q) begin
            // Idle: just retarget; the request rises on a later quiet edge.
            addr_d = redir_pc_aligned;
         end else if (!imem_ack_i) begin
            // Read in flight: keep it stable for memory, drop its data later.
            squash_d = 1'b1;
         end else begin
            // Read completes now: its data is dropped, fetch continues at target.
            addr_d   = redir_pc_aligned;
            squash_d = 1'b0;
            req_d    = 1'b1;
         end
      end else if (!req_q) begin
         req_d = space;
      end else if (imem_ack_i) begin
         addr_d   = squash_q ? redir_pc_q : addr_q + 32'd4;
         squash_d = 1'b0;
         req_d    = space;
      end
   end

   // Control and pointer registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_q      <= 1'b0;
         addr_q     <= PC_RESET;
         squash_q   <= 1'b0;
         redir_pc_q <= PC_RESET;
         level_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         req_q      <= req_d;
         addr_q     <= addr_d;
         squash_q   <= squash_d;
         redir_pc_q <= redir_pc_d;
         level_q    <= level_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Queue storage write port.
   // NOTE: storage is not reset; level_q alone decides which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{pc: addr_q, instr: imem_data_i};
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus random
// traffic compared each cycle against a transaction-level model (a queue of
// {pc,instr} plus the next fetch PC and the in-flight read).
module tb_instr_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          LW       = $clog2(DEPTH) + 1;
   localparam logic [31:0] PC_RESET = 32'h0000_0000;
   localparam int          VW       = 120 + LW;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            imem_req;
   logic [31:0]     imem_addr;
   logic            imem_ack = 1'b0;
   logic [31:0]     imem_data = '0;
   logic            redirect = 1'b0;
   logic [31:0]     redirect_pc = '0;
   logic            dec_valid;
   logic            dec_ready = 1'b0;
   logic [31:0]     dec_instr;
   logic [31:0]     dec_pc;
   logic [5:0]      dec_opcode;
   logic [15:0]     dec_imm16;
   logic [LW-1:0]   level;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_fetch_queue #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ack_i    (imem_ack),
      .imem_data_i   (imem_data),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .dec_valid_o   (dec_valid),
      .dec_ready_i   (dec_ready),
      .dec_instr_o   (dec_instr),
      .dec_pc_o      (dec_pc),
      .dec_opcode_o  (dec_opcode),
      .dec_imm16_o   (dec_imm16),
      .level_o       (level)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      mq[$];
   bit          m_infl;
   bit          m_dead;
   logic [31:0] m_pc;
   logic [31:0] m_infl_addr;

   logic        e_req;
   logic [31:0] e_addr;
   logic        e_valid;
   logic [31:0] e_instr;
   logic [31:0] e_pc;
   int          e_level;

   task automatic model_reset();
      mq.delete();
      m_infl      = 1'b0;
      m_dead      = 1'b0;
      m_pc        = PC_RESET;
      m_infl_addr = PC_RESET;
   endtask

   function automatic bit bypass_now();
`ifdef IFQ_BYPASS_EN
      return (mq.size() == 0) && m_infl && imem_ack && !m_dead && !redirect;
`else
      return 1'b0;
`endif
   endfunction

   task automatic compute_exp();
      e_req   = m_infl;
      e_addr  = m_infl ? m_infl_addr : m_pc;
      e_level = mq.size();
      if (bypass_now()) begin
         e_valid = 1'b1; e_instr = imem_data; e_pc = m_infl_addr;
      end else if (mq.size() > 0) begin
         e_valid = 1'b1; e_instr = mq[0].instr; e_pc = mq[0].pc;
      end else begin
         e_valid = 1'b0; e_instr = '0; e_pc = '0;
      end
   endtask

   task automatic model_edge();
      bit acked;
      bit byp;
      acked = m_infl && imem_ack;
      byp   = bypass_now();
      if (redirect) begin
         mq.delete();
         m_pc = {redirect_pc[31:2], 2'b00};
         if (m_infl && !imem_ack) begin
            m_dead = 1'b1;
         end else if (acked) begin
            m_dead      = 1'b0;
            m_infl_addr = m_pc;
            m_pc        = m_pc + 32'd4;
         end
      end else begin
         if (mq.size() > 0 && dec_ready) void'(mq.pop_front());
         if (acked) begin
            if (!m_dead && !(byp && dec_ready))
               mq.push_back('{pc: m_infl_addr, instr: imem_data});
            m_dead = 1'b0;
            m_infl = 1'b0;
         end
         if (!m_infl && mq.size() < DEPTH) begin
            m_infl      = 1'b1;
            m_infl_addr = m_pc;
            m_pc        = m_pc + 32'd4;
         end
      end
   endtask

   task automatic drive(input bit a, input logic [31:0] d, input bit r,
                        input bit rd, input logic [31:0] rp);
      imem_ack    = a;
      imem_data   = d;
      dec_ready   = r;
      redirect    = rd;
      redirect_pc = rp;
      compute_exp();
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
      checks++; if (imem_addr !== PC_RESET) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, PC_RESET); end
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dec_valid); end
      checks++; if (dec_instr !== 32'h0 || dec_pc !== 32'h0) begin errors++; $display("FAIL reset_dec: instr %h pc %h want 0", dec_instr, dec_pc); end
      checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_stream();
      test_reset();
      for (int i = 0; i < 12; i++) begin
         drive(m_infl, $urandom, 1'b1, 1'b0, '0);
         @(negedge clk);
         checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, imem_addr, 4 * i); end
         checks++; if (dec_valid !== e_valid || dec_pc !== e_pc) begin errors++; $display("FAIL stream_pc[%0d]: got %b/%h want %b/%h", i, dec_valid, dec_pc, e_valid, e_pc); end
         checks++; if (dec_imm16 !== e_instr[15:0]) begin errors++; $display("FAIL stream_imm[%0d]: got %h want %h", i, dec_imm16, e_instr[15:0]); end
         tick();
      end
   endtask

   task automatic test_backpressure();
      test_reset();
      for (int i = 0; i < 6; i++) begin
         drive(m_infl, 32'h1000 + 32'(i), 1'b0, 1'b0, '0);
         @(negedge clk);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL bp_level: got %0d want %0d", level, DEPTH); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %b want 0", imem_req); end
      tick();
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      @(negedge clk);
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got %b/%h want 1/0", dec_valid, dec_pc); end
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL bp_resume: got %b/%h want 1/00000010", imem_req, imem_addr); end
      tick();
   endtask

   task automatic test_redirect_squash();
      test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, '0);
         @(negedge clk);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b1, 32'h100);
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL sq_pending: got %b/%h want 1/00000008", imem_req, imem_addr); end
      tick();
      drive(1'b1, 32'hDEAD_0008, 1'b1, 1'b0, '0);
      @(negedge clk);
      checks++; if (imem_addr !== 32'h8 || dec_valid !== 1'b0) begin errors++; $display("FAIL sq_held: addr %h valid %b want 00000008/0", imem_addr, dec_valid); end
      tick();
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || dec_valid !== 1'b0) begin errors++; $display("FAIL sq_reissue: got %b/%h/%b want 1/00000100/0", imem_req, imem_addr, dec_valid); end
      tick();
      drive(1'b1, 32'h1111_0100, 1'b0, 1'b0, '0);
      @(negedge clk);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100 || dec_instr !== 32'h1111_0100) begin errors++; $display("FAIL sq_target: got %b/%h/%h want 1/00000100/11110100", dec_valid, dec_pc, dec_instr); end
      tick();
   endtask

   task automatic test_redirect_ack();
      test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0, '0);
         @(negedge clk);
         tick();
      end
      drive(1'b1, 32'h0BAD_0BAD, 1'b1, 1'b1, 32'h40);
      @(negedge clk);
      checks++; if (level !== LW'(2)) begin errors++; $display("FAIL ra_pre_level: got %0d want 2", level); end
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checks++; if (level !== '0 || dec_valid !== 1'b0) begin errors++; $display("FAIL ra_flush: level %0d valid %b want 0/0", level, dec_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL ra_req: got %b/%h want 1/00000040", imem_req, imem_addr); end
      tick();
      drive(1'b1, 32'h2222_0040, 1'b0, 1'b0, '0);
      @(negedge clk);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h40) begin errors++; $display("FAIL ra_next_pc: got %b/%h want 1/00000040", dec_valid, dec_pc); end
      tick();
   endtask

   task automatic test_align_wrap();
      test_reset();
      drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h203);
      @(negedge clk);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL align_addr: got %h want 00000200", imem_addr); end
      tick();
      drive(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      @(negedge clk);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h want fffffffc", imem_addr); end
      tick();
      drive(1'b1, 32'h3333_FFFC, 1'b0, 1'b0, '0);
      @(negedge clk);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %b/%h want 1/00000000", imem_req, imem_addr); end
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %b/%h want 1/fffffffc", dec_valid, dec_pc); end
      tick();
   endtask

   task automatic test_latency();
      test_reset();
      drive(1'b1, 32'h2008_FFFF, 1'b0, 1'b0, '0);
      @(negedge clk);
`ifdef IFQ_BYPASS_EN
      checks++; if (dec_valid !== 1'b1 || dec_imm16 !== 16'hFFFF || dec_opcode !== 6'h08 || dec_pc !== 32'h0) begin errors++; $display("FAIL lat_bypass: got %b/%h/%h/%h want 1/ffff/08/00000000", dec_valid, dec_imm16, dec_opcode, dec_pc); end
`else
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL lat_nobypass: got %b want 0", dec_valid); end
`endif
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checks++; if (dec_valid !== 1'b1 || dec_imm16 !== 16'hFFFF || dec_opcode !== 6'h08) begin errors++; $display("FAIL lat_next: got %b/%h/%h want 1/ffff/08", dec_valid, dec_imm16, dec_opcode); end
      tick();
   endtask

   task automatic test_random();
      logic [VW-1:0] obs;
      logic [VW-1:0] exp;
      logic [31:0]   rp;
      test_reset();
      for (int i = 0; i < 1500; i++) begin
         rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
         drive(m_infl && ($urandom_range(0, 9) < 7), $urandom,
               $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, rp);
         @(negedge clk);
         obs = {imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_opcode, dec_imm16, level};
         exp = {e_req, e_addr, e_valid, e_instr, e_pc, e_instr[31:26], e_instr[15:0], LW'(e_level)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL random[%0d]: got %h want %h", i, obs, exp);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_squash();
      test_redirect_ack();
      test_align_wrap();
      test_latency();
      test_random();
      test_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
